b_resp_arbiter: RTL and testbench
=================================

# b_resp_arbiter

Round-robin arbiter that merges up to N_SRC write-response (B-channel) streams onto one downstream B port through a single registered output stage. Sits in the master-side clock domain, after the 2-entry B-channel CDC FIFOs (one per source). It drains their read sides and presents one valid/ready stream, with 10-bit beats of 8-bit ID and 2-bit response, to the master interface. Grants rotate fairly and advance only on accepted beats, and the block sustains one beat per cycle.

## Interface
- N_SRC, 3: number of requesting B streams (2..8).
- DW, 10: beat width ({id[7:0], resp[1:0]}); passed through untouched.
- clk  input  1  single clock; all state samples on posedge.
- rst  input  1  reset, asynchronous, active-high.
- src_valid  input  N_SRC  per-source beat available (FIFO rrdy).
- src_data  input  N_SRC*DW  per-source beat; source i at bits [i*DW +: DW].
- src_ready  output  N_SRC  per-source pop (FIFO rget); at most one bit high per cycle.
- out_valid  output  1  output register holds a beat.
- out_data  output  DW  registered beat.
- out_ready  input  1  downstream accepts beat.
- out_src  output  clog2(N_SRC) (min 1)  index of source that produced out_data.
- busy  output  1  out_valid | (|src_valid).

## Operation
- Output register states: EMPTY (out_valid=0) and FULL (out_valid=1).
- The stage can load in a cycle when it is EMPTY, or when it is FULL and out_ready=1 (pass-through refill). Call this condition `can_load`.
- Winner: the first i with src_valid[i]=1, scanning ptr, ptr+1, ... ptr+N_SRC-1 mod N_SRC.
- src_ready[winner] = can_load & src_valid[winner]; all other src_ready bits are 0. src_ready is combinational from src_valid, ptr, out_valid and out_ready. It never depends on a source's ready-before-valid.
- On a source handshake: out_data <= src_data[winner], out_src <= winner, out_valid <= 1, ptr <= (winner+1) mod N_SRC.
- On output handshake (out_valid & out_ready) with no source handshake in the same cycle: out_valid <= 0, and out_data/out_src hold their old value.
- When out_valid=1 and out_ready=0: out_data and out_src are stable, all src_ready=0, and ptr does not move.
- ptr changes only on a source handshake. Idle cycles and deasserted src_valid do not rotate it.
- A source that drops src_valid before it is granted loses its turn without penalty.
- Data is never dropped, duplicated or reordered within one source. Cross-source order follows grant order.

## Timing
- Reset (async, rst=1): out_valid=0, out_data=0, out_src=0, ptr=0, src_ready=0, busy=|src_valid. These values hold while rst=1. The output is cleared immediately even mid-beat, and a pending beat is discarded.
- The first cycle after rst falls is an arbitration cycle. Source 0 has highest priority.
- Latency: a source handshake at edge k makes out_valid=1 and out_data valid immediately after edge k. The earliest downstream accept is at edge k+1.
- Throughput: 1 beat/cycle with out_ready held high, via refill in the same cycle as drain.
- All N_SRC valid continuously with out_ready=1: grants go 0,1,2,0,1,2,... with one per cycle.
- A single source continuously valid: it is granted every cycle, back-to-back.
- N_SRC not a power of two: ptr wraps from N_SRC-1 to 0 and never takes values ≥ N_SRC.

## Test plan
- Reset mid-beat: load beat 0x2A5 from src1 with out_ready=0, then pulse rst → out_valid=0, out_data=0 within the same cycle, and src_ready=0 while rst=1. After release, with src0 and src2 valid, src0 is granted first.
- Round-robin fairness: src0..2 always valid with data 0x100+i, out_ready=1 for 9 cycles → out_src sequence 0,1,2,0,1,2,0,1,2, one beat per cycle, and src_ready is one-hot every cycle.
- Backpressure: hold out_ready=0 for 5 cycles with all sources valid → out_data stays stable, src_ready=0 and ptr is unchanged. When out_ready rises, the drain and the next grant happen in the same cycle.
- Pointer skip: ptr=1, only src0 valid → src0 granted and ptr becomes 1. Then src0 and src1 valid → src1 granted before src0.
- Sparse traffic: src2 valid alone for one cycle, then idle 4 cycles, then src0 and src2 valid → grant order 2, then 0, then 2. ptr does not move during the idle gap.
- Integration with two CDC FIFOs (write-side clock ≠ clk): push 20 random beats per FIFO → all 40 appear once at the output, in per-source order, with correct out_src.

Source files
------------

// File: rtl/b_resp_arbiter.sv
// b_resp_arbiter: round-robin merge of N_SRC B-channel streams into one
// registered valid/ready output. Grants rotate only on accepted source beats,
// and the output register refills in the same cycle it drains so one beat per
// cycle is sustained.
module b_resp_arbiter #(
  parameter int N_SRC = 3,
  parameter int DW    = 10,
  localparam int SW   = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_SRC-1:0]      src_valid,
  input  logic [N_SRC*DW-1:0]   src_data,
  output logic [N_SRC-1:0]      src_ready,
  output logic                  out_valid,
  output logic [DW-1:0]         out_data,
  input  logic                  out_ready,
  output logic [SW-1:0]         out_src,
  output logic                  busy
);

  // Index space rounded up to a power of two so the winner index selects
  // the data array at its natural width; unused slots read as zero.
  localparam int NP = 1 << SW;

  logic [SW-1:0] r_ptr;
  logic          r_out_valid;
  logic [DW-1:0] r_out_data;
  logic [SW-1:0] r_out_src;

  logic [DW-1:0] w_data_arr [NP];
  logic [SW-1:0] w_winner;
  logic          w_found;
  logic          w_can_load;
  logic          w_load;
  logic [SW-1:0] w_ptr_next;

  genvar gi;
  generate
    for (gi = 0; gi < NP; gi++) begin : g_data
      if (gi < N_SRC) begin : g_real
        assign w_data_arr[gi] = src_data[gi*DW +: DW];
      end else begin : g_pad
        assign w_data_arr[gi] = '0;
      end
    end
  endgenerate

  // Winner search: scan from ptr upward with wrap; iterating from the
  // farthest offset down lets the nearest valid source overwrite the result.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      if (src_valid[SW'((int'(r_ptr) + k) % N_SRC)]) begin
        w_found  = 1'b1;
        w_winner = SW'((int'(r_ptr) + k) % N_SRC);
      end
    end
  end

  // The stage accepts a new beat when empty or when the held beat leaves now.
  // Reset suppresses every pop so nothing is taken from a source while the
  // output is being cleared.
  assign w_can_load = !r_out_valid || out_ready;
  assign w_load     = w_can_load && w_found && !rst;
  assign w_ptr_next = (w_winner == SW'(N_SRC - 1)) ? '0 : w_winner + SW'(1);

  generate
    for (gi = 0; gi < N_SRC; gi++) begin : g_ready
      assign src_ready[gi] = w_load && (w_winner == SW'(gi));
    end
  endgenerate

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_src   = r_out_src;
  assign busy      = r_out_valid | (|src_valid);

  // Output register and grant pointer: load on source handshake, empty on a
  // drain with no refill, otherwise hold (pointer moves only on a load).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= '0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_data_arr[w_winner];
      r_out_src   <= w_winner;
      r_ptr       <= w_ptr_next;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_b_resp_arbiter.sv
// Directed bench for b_resp_arbiter with a per-source expected-beat
// scoreboard, finishing with two behavioural 2-entry FIFOs written from a
// second clock.
module tb_b_resp_arbiter;
  localparam int N  = 3;
  localparam int DW = 10;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            wclk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    src_valid = '0;
  logic [N*DW-1:0] src_data = '0;
  logic [N-1:0]    src_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic            out_ready = 1'b0;
  logic [SW-1:0]   out_src;
  logic            busy;

  int n_vec  = 0;
  int n_err  = 0;
  int n_push = 0;
  int n_rx   = 0;

  logic [DW-1:0] sb [N][$];
  logic [DW-1:0] fq [2][$];
  bit            fifo_mode = 1'b0;
  logic [1:0]    pop_q = '0;

  b_resp_arbiter #(.N_SRC(N), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .out_src(out_src), .busy(busy)
  );

  always #5 clk = ~clk;
  always #7 wclk = ~wclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int s, input logic [DW-1:0] d);
    src_data[s*DW +: DW] = d;
  endtask

  task automatic expect_beat(input int s, input logic [DW-1:0] d);
    sb[s].push_back(d);
    n_push++;
  endtask

  task automatic writer(input int s);
    logic [DW-1:0] d;
    for (int k = 0; k < 20; k++) begin
      d = DW'($urandom);
      do @(posedge wclk); while (fq[s].size() >= 2);
      #1;
      fq[s].push_back(d);
      expect_beat(s, d);
      repeat ($urandom_range(0, 2)) @(posedge wclk);
    end
  endtask

  // Output monitor: every accepted beat must be the oldest expected beat of
  // the source it claims to come from.
  always @(negedge clk) begin
    logic [DW-1:0] e;
    if (!rst && out_valid && out_ready) begin
      n_rx++;
      if (int'(out_src) < N) begin
        check("sb_has_entry", 32'(sb[out_src].size() != 0), 32'd1);
        if (sb[out_src].size() != 0) begin
          e = sb[out_src].pop_front();
          check($sformatf("beat_src%0d", out_src), 32'(out_data), 32'(e));
        end
      end else begin
        check("out_src_range", 32'(out_src), 32'(N - 1));
      end
    end
  end

  // FIFO read side: record pops at the falling edge, retire them and
  // present the new head just after the rising edge.
  always @(negedge clk) pop_q = src_valid[1:0] & src_ready[1:0];

  always @(posedge clk) begin
    if (fifo_mode) begin
      #1;
      for (int s = 0; s < 2; s++) begin
        if (pop_q[s] && fq[s].size() != 0) void'(fq[s].pop_front());
        src_valid[s] = (fq[s].size() != 0);
        src_data[s*DW +: DW] = (fq[s].size() != 0) ? fq[s][0] : '0;
      end
      src_valid[2] = 1'b0;
    end
  end

  initial begin
    int base;
    // Reset values
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_src", 32'(out_src), 32'd0);
    check("rst_src_ready", 32'(src_ready), 32'd0);
    check("rst_busy_idle", 32'(busy), 32'd0);
    src_valid = 3'b111;
    #1;
    check("rst_ready_valid", 32'(src_ready), 32'd0);
    check("rst_busy_valid", 32'(busy), 32'd1);
    src_valid = '0;
    @(posedge clk); #1 rst = 1'b0;

    // Reset mid-beat
    set_data(1, 10'h2A5);
    src_valid = 3'b010;
    out_ready = 1'b0;
    #1 check("rm_grant1", 32'(src_ready), 32'b010);
    step();
    check("rm_loaded_v", 32'(out_valid), 32'd1);
    check("rm_loaded_d", 32'(out_data), 32'h2A5);
    check("rm_loaded_s", 32'(out_src), 32'd1);
    src_valid = '0;
    #2 rst = 1'b1;
    #1;
    check("rm_clr_v", 32'(out_valid), 32'd0);
    check("rm_clr_d", 32'(out_data), 32'd0);
    check("rm_clr_s", 32'(out_src), 32'd0);
    set_data(0, 10'h011);
    set_data(2, 10'h033);
    src_valid = 3'b101;
    #1;
    check("rm_hold_ready", 32'(src_ready), 32'd0);
    check("rm_hold_busy", 32'(busy), 32'd1);
    @(posedge clk); #1 rst = 1'b0;
    out_ready = 1'b1;
    #1 check("rm_first_src0", 32'(src_ready), 32'b001);
    expect_beat(0, 10'h011);
    step();
    check("rm_out_src0", 32'(out_src), 32'd0);
    src_valid = 3'b100;
    #1 check("rm_next_src2", 32'(src_ready), 32'b100);
    expect_beat(2, 10'h033);
    step();
    check("rm_out_src2", 32'(out_src), 32'd2);
    src_valid = '0;
    step();
    check("rm_drained", 32'(out_valid), 32'd0);

    // Round-robin fairness at full rate
    for (int s = 0; s < N; s++) set_data(s, DW'(10'h100 + s));
    src_valid = 3'b111;
    for (int i = 0; i < 9; i++) begin
      #1 check($sformatf("rr_ready_%0d", i), 32'(src_ready), 32'(1 << (i % 3)));
      expect_beat(i % 3, DW'(10'h100 + (i % 3)));
      step();
      check($sformatf("rr_src_%0d", i), 32'(out_src), 32'(i % 3));
      check($sformatf("rr_valid_%0d", i), 32'(out_valid), 32'd1);
    end
    src_valid = '0;
    step();
    check("rr_drained", 32'(out_valid), 32'd0);

    // Backpressure
    for (int s = 0; s < N; s++) set_data(s, DW'(10'h0A0 + s));
    src_valid = 3'b111;
    out_ready = 1'b0;
    #1 check("bp_grant0", 32'(src_ready), 32'b001);
    expect_beat(0, 10'h0A0);
    step();
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("bp_ready_%0d", i), 32'(src_ready), 32'd0);
      check($sformatf("bp_data_%0d", i), 32'(out_data), 32'h0A0);
      check($sformatf("bp_src_%0d", i), 32'(out_src), 32'd0);
      check($sformatf("bp_valid_%0d", i), 32'(out_valid), 32'd1);
      step();
    end
    out_ready = 1'b1;
    #1 check("bp_release_grant1", 32'(src_ready), 32'b010);
    expect_beat(1, 10'h0A1);
    step();
    check("bp_refill_src", 32'(out_src), 32'd1);
    check("bp_refill_data", 32'(out_data), 32'h0A1);
    src_valid = '0;
    step();

    // Pointer skip (ptr is 2 here; a lone src0 grant moves it to 1)
    set_data(0, 10'h050);
    src_valid = 3'b001;
    #1 check("ps_a_ready", 32'(src_ready), 32'b001);
    expect_beat(0, 10'h050);
    step();
    check("ps_a_src", 32'(out_src), 32'd0);
    set_data(0, 10'h052);
    #1 check("ps_b_ready", 32'(src_ready), 32'b001);
    expect_beat(0, 10'h052);
    step();
    check("ps_b_src", 32'(out_src), 32'd0);
    set_data(0, 10'h054);
    set_data(1, 10'h051);
    src_valid = 3'b011;
    #1 check("ps_c_src1_first", 32'(src_ready), 32'b010);
    expect_beat(1, 10'h051);
    step();
    check("ps_c_src", 32'(out_src), 32'd1);
    #1 check("ps_d_src0_next", 32'(src_ready), 32'b001);
    expect_beat(0, 10'h054);
    step();
    check("ps_d_src", 32'(out_src), 32'd0);
    src_valid = '0;
    step();

    // Sparse traffic (ptr is 1 here)
    set_data(2, 10'h3C2);
    src_valid = 3'b100;
    #1 check("sp_grant2", 32'(src_ready), 32'b100);
    expect_beat(2, 10'h3C2);
    step();
    src_valid = '0;
    for (int i = 0; i < 4; i++) begin
      #1 check($sformatf("sp_idle_ready_%0d", i), 32'(src_ready), 32'd0);
      step();
    end
    check("sp_idle_busy", 32'(busy), 32'd0);
    set_data(0, 10'h3C0);
    set_data(2, 10'h3C4);
    src_valid = 3'b101;
    #1 check("sp_grant0", 32'(src_ready), 32'b001);
    expect_beat(0, 10'h3C0);
    step();
    #1 check("sp_grant2_again", 32'(src_ready), 32'b100);
    expect_beat(2, 10'h3C4);
    step();
    check("sp_last_src", 32'(out_src), 32'd2);
    src_valid = '0;
    step();

    // Two FIFOs written from wclk, drained with random backpressure
    base = n_rx;
    fifo_mode = 1'b1;
    fork
      writer(0);
      writer(1);
    join_none
    for (int c = 0; c < 3000 && (n_rx - base) < 40; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    out_ready = 1'b1;
    step();
    step();
    check("fifo_rx_count", 32'(n_rx - base), 32'd40);
    fifo_mode = 1'b0;
    for (int s = 0; s < N; s++)
      check($sformatf("sb_empty_%0d", s), 32'(sb[s].size()), 32'd0);
    check("rx_total", 32'(n_rx), 32'(n_push));
    check("end_idle", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
